// File: rtl/ff_excitation_sequencer_if.sv
// Control bus and flip-flop excitation/observation signals of the excitation sequencer.
// slave = sequencer side, master = controller / flip-flop side.
interface ff_excitation_sequencer_if #(parameter int N = 8);
  logic         start;
  logic         abort;
  logic [N-1:0] pattern;
  logic [3:0]   len;
  logic         q_sr, q_jk, q_t;
  logic         ff_reset;
  logic         s, r, j, k, t;
  logic         busy, done;
  logic         err_sr, err_jk, err_t;
  logic [3:0]   mism_cnt;

  modport slave (
    input  start, abort, pattern, len, q_sr, q_jk, q_t,
    output ff_reset, s, r, j, k, t, busy, done, err_sr, err_jk, err_t, mism_cnt
  );

  modport master (
    output start, abort, pattern, len, q_sr, q_jk, q_t,
    input  ff_reset, s, r, j, k, t, busy, done, err_sr, err_jk, err_t, mism_cnt
  );
endinterface

// File: rtl/ff_excitation_sequencer.sv
// Drives SR/JK/T flip-flops through a target Q pattern and checks each one
// follows it with a one-step lag; flags and counts mismatches per run.
module ff_excitation_sequencer #(
  parameter int N = 8
) (
  input logic                    clk,
  input logic                    reset,
  ff_excitation_sequencer_if.slave bus
);
  localparam int W = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, INIT, RUN, CHECK} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pattern_q;
  logic [3:0]   len_q;
  logic [W-1:0] step_q;
  logic [W-1:0] l_eff;
  logic         done_q;
  logic         err_sr_q, err_jk_q, err_t_q;
  logic [3:0]   mism_q;

  logic [N-1:0] pat_cur, pat_prev, pat_last;
  logic         tg, q_exp, last_step, cmp_en;
  logic         m_sr, m_jk, m_t;
  int           len_i;

  always_comb begin
    len_i    = int'(len_q);
    l_eff    = (len_q == 4'd0 || len_i > N) ? W'(N) : W'(len_i);
    pat_cur  = pattern_q >> step_q;
    pat_prev = pattern_q >> (step_q - W'(1));
    pat_last = pattern_q >> (l_eff - W'(1));
    tg       = pat_cur[0];
    last_step = (step_q == l_eff - W'(1));
    // a flip-flop shows step i's target one cycle later, so compares lag by one
    if (state_q == CHECK) q_exp = pat_last[0];
    else if (step_q == '0) q_exp = 1'b0;
    else q_exp = pat_prev[0];
    cmp_en = (state_q == RUN || state_q == CHECK) && !bus.abort;
    m_sr   = cmp_en && (bus.q_sr != q_exp);
    m_jk   = cmp_en && (bus.q_jk != q_exp);
    m_t    = cmp_en && (bus.q_t  != q_exp);
  end

  always_comb begin
    bus.s = 1'b0;
    bus.r = 1'b0;
    bus.j = 1'b0;
    bus.k = 1'b0;
    bus.t = 1'b0;
    if (state_q == RUN) begin
      bus.s = tg & ~bus.q_sr;
      bus.r = ~tg & bus.q_sr;
      bus.j = tg;
      bus.k = ~tg;
      bus.t = tg ^ bus.q_t;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = INIT;
      INIT:    state_d = RUN;
      RUN:     if (last_step) state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort && state_q != IDLE) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      step_q    <= '0;
      done_q    <= 1'b0;
      err_sr_q  <= 1'b0;
      err_jk_q  <= 1'b0;
      err_t_q   <= 1'b0;
      mism_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == CHECK) && !bus.abort;
      if (state_q == IDLE && bus.start) begin
        pattern_q <= bus.pattern;
        len_q     <= bus.len;
        step_q    <= '0;
        err_sr_q  <= 1'b0;
        err_jk_q  <= 1'b0;
        err_t_q   <= 1'b0;
        mism_q    <= '0;
      end else begin
        if (state_q == RUN && !last_step) step_q <= step_q + W'(1);
        err_sr_q <= err_sr_q | m_sr;
        err_jk_q <= err_jk_q | m_jk;
        err_t_q  <= err_t_q | m_t;
        if ((m_sr || m_jk || m_t) && mism_q != 4'hF) mism_q <= mism_q + 4'd1;
      end
    end
  end

  assign bus.ff_reset = (state_q == INIT);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.err_sr   = err_sr_q;
  assign bus.err_jk   = err_jk_q;
  assign bus.err_t    = err_t_q;
  assign bus.mism_cnt = mism_q;
endmodule

// File: tb/tb_ff_excitation_sequencer.sv
// Directed bench: ideal SR/JK/T models (optionally T stuck at 0) around the sequencer.
module tb_ff_excitation_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  ff_excitation_sequencer_if #(.N(8)) bus();

  ff_excitation_sequencer #(.N(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic qsr_m = 1'b0, qjk_m = 1'b0, qt_m = 1'b0;
  logic t_stuck = 1'b0;

  always @(posedge clk) begin
    if (bus.ff_reset) begin
      qsr_m <= 1'b0; qjk_m <= 1'b0; qt_m <= 1'b0;
    end else begin
      if (bus.s) qsr_m <= 1'b1;
      else if (bus.r) qsr_m <= 1'b0;
      if (bus.j && bus.k) qjk_m <= ~qjk_m;
      else if (bus.j) qjk_m <= 1'b1;
      else if (bus.k) qjk_m <= 1'b0;
      if (bus.t) qt_m <= ~qt_m;
    end
  end

  assign bus.q_sr = qsr_m;
  assign bus.q_jk = qjk_m;
  assign bus.q_t  = t_stuck ? 1'b0 : qt_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // leaves the bench in cycle 1 (start was high in cycle 0)
  task automatic start_run(input logic [7:0] pat, input logic [3:0] ln, input logic ab);
    bus.start = 1'b1; bus.pattern = pat; bus.len = ln; bus.abort = ab;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
  endtask

  function automatic logic [4:0] exc();
    return {bus.s, bus.r, bus.j, bus.k, bus.t};
  endfunction

  function automatic logic [3:0] errs();
    return {bus.err_sr, bus.err_jk, bus.err_t, 1'b0};
  endfunction

  initial begin
    logic [7:0] pat;
    logic       expq;
    logic       seen_done;

    bus.start = 1'b0; bus.abort = 1'b0; bus.pattern = '0; bus.len = '0;
    tick(); tick();
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    reset = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ffreset", bus.ff_reset, 0);
    chk("rst_errs", errs(), 0);
    chk("rst_mism", bus.mism_cnt, 0);
    chk("rst_exc", exc(), 0);

    // ideal run, len=0 -> 8 steps; stray start mid-run must be ignored
    pat = 8'b10110010;
    start_run(pat, 4'd0, 1'b0);
    chk("r1_c1_ffreset", bus.ff_reset, 1);
    chk("r1_c1_busy", bus.busy, 1);
    chk("r1_c1_exc", exc(), 0);
    tick();
    chk("r1_step0_exc", exc(), 5'b00010);
    for (int i = 0; i < 8; i++) begin
      expq = (i == 0) ? 1'b0 : pat[i-1];
      chk($sformatf("r1_q_sr_%0d", i), bus.q_sr, expq);
      chk($sformatf("r1_q_jk_%0d", i), bus.q_jk, expq);
      chk($sformatf("r1_q_t_%0d", i), bus.q_t, expq);
      if (i == 1) chk("r1_step1_exc", exc(), 5'b10101);
      if (bus.s && bus.r) chk("r1_s_r_both", 1, 0);
      if (i == 2) begin
        bus.start = 1'b1; bus.pattern = 8'h0F; bus.len = 4'd2;
      end else bus.start = 1'b0;
      tick();
    end
    bus.start = 1'b0;
    chk("r1_c10_busy", bus.busy, 1);
    chk("r1_c10_done", bus.done, 0);
    chk("r1_c10_q", bus.q_sr, pat[7]);
    tick();
    chk("r1_c11_done", bus.done, 1);
    chk("r1_c11_busy", bus.busy, 0);
    chk("r1_errs", errs(), 0);
    chk("r1_mism", bus.mism_cnt, 0);
    chk("r1_c11_exc", exc(), 0);
    tick();
    chk("r1_c12_done", bus.done, 0);

    // T stuck at 0, all-ones target, 4 steps
    t_stuck = 1'b1;
    start_run(8'hFF, 4'd4, 1'b0);
    for (int c = 1; c < 6; c++) tick();
    chk("r2_c6_done", bus.done, 0);
    chk("r2_c6_busy", bus.busy, 1);
    tick();
    chk("r2_c7_done", bus.done, 1);
    chk("r2_err_t", bus.err_t, 1);
    chk("r2_err_sr", bus.err_sr, 0);
    chk("r2_err_jk", bus.err_jk, 0);
    chk("r2_mism", bus.mism_cnt, 4);
    t_stuck = 1'b0;
    tick();

    // abort in cycle 4 of an 8-step run
    start_run(8'hB2, 4'd8, 1'b0);
    chk("r3_cleared_err", errs(), 0);
    chk("r3_cleared_mism", bus.mism_cnt, 0);
    tick(); tick(); tick();
    bus.abort = 1'b1;
    chk("r3_c4_busy", bus.busy, 1);
    tick();
    bus.abort = 1'b0;
    chk("r3_c5_busy", bus.busy, 0);
    chk("r3_c5_exc", exc(), 0);
    seen_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      seen_done |= bus.done;
      tick();
    end
    chk("r3_no_done", seen_done, 0);
    chk("r3_mism_hold", bus.mism_cnt, 0);

    // abort alone in idle is ignored
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("idle_abort_busy", bus.busy, 0);

    // start+abort together starts; single-step run
    start_run(8'h01, 4'd1, 1'b1);
    chk("r4_c1_busy", bus.busy, 1);
    chk("r4_c1_ffreset", bus.ff_reset, 1);
    tick();
    chk("r4_step0_exc", exc(), 5'b10101);
    tick();
    chk("r4_c3_check_busy", bus.busy, 1);
    tick();
    chk("r4_c4_done", bus.done, 1);
    chk("r4_errs", errs(), 0);

    // len > N clamps to N
    start_run(8'hB2, 4'd12, 1'b0);
    for (int c = 1; c < 10; c++) tick();
    chk("r5_c10_busy", bus.busy, 1);
    chk("r5_c10_done", bus.done, 0);
    tick();
    chk("r5_c11_done", bus.done, 1);
    chk("r5_mism", bus.mism_cnt, 0);

    // reset mid-run, then a fresh 3-step run
    start_run(8'hFF, 4'd8, 1'b0);
    t_stuck = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    t_stuck = 1'b0;
    chk("r6_rst_busy", bus.busy, 0);
    chk("r6_rst_done", bus.done, 0);
    chk("r6_rst_ffreset", bus.ff_reset, 0);
    chk("r6_rst_exc", exc(), 0);
    chk("r6_rst_errs", errs(), 0);
    chk("r6_rst_mism", bus.mism_cnt, 0);
    seen_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      seen_done |= bus.done;
      tick();
    end
    chk("r6_no_done", seen_done, 0);
    start_run(8'h05, 4'd3, 1'b0);
    for (int c = 1; c < 5; c++) tick();
    chk("r7_c5_done", bus.done, 0);
    tick();
    chk("r7_c6_done", bus.done, 1);
    chk("r7_errs", errs(), 0);
    chk("r7_mism", bus.mism_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ff_excitation_sequencer.md
FF_EXCITATION_SEQUENCER -- requirements
Module: ff_excitation_sequencer

Interface
REQ-001 Parameter: N, default 8, maximum pattern length in steps.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request a run; sampled only in IDLE.
REQ-005 Port: abort  input  1  terminate a run in progress.
REQ-006 Port: pattern  input  N  target Q sequence; bit i is the target for step i; latched on start.
REQ-007 Port: len  input  4  step count; latched on start.
REQ-008 Port: q_sr, q_jk, q_t  input  1 each  observed Q of the external SR, JK and T flip-flops.
REQ-009 Port: ff_reset  output  1  reset pulse to the external flip-flops.
REQ-010 Port: s, r  output  1 each  SR excitation.
REQ-011 Port: j, k  output  1 each  JK excitation.
REQ-012 Port: t  output  1  T excitation.
REQ-013 Port: busy  output  1  high while not in IDLE.
REQ-014 Port: done  output  1  one-cycle completion pulse.
REQ-015 Port: err_sr, err_jk, err_t  output  1 each  sticky per-run mismatch flags.
REQ-016 Port: mism_cnt  output  4  count of compare cycles with any mismatch.

Function
REQ-017 FSM states SHALL be IDLE, INIT, RUN and CHECK.
REQ-018 IDLE->INIT on start=1; pattern and len are latched, err_* and mism_cnt are cleared, and step index is set to 0.
REQ-019 Latched len SHALL be 0 or greater than N -> use N; 1..N -> use as given (L).
REQ-020 INIT SHALL last exactly 1 cycle with ff_reset=1, then go to RUN; ff_reset=0 in all other states.
REQ-021 RUN SHALL last exactly L cycles; step i = 0..L-1; after step L-1, go to CHECK.
REQ-022 CHECK SHALL last 1 cycle, then go to IDLE; done=1 (registered) in the first IDLE cycle after CHECK only.
REQ-023 From start high in cycle 0: INIT in cycle 1, RUN in cycles 2..L+1, CHECK in cycle L+2, done in cycle L+3.
REQ-024 Excitations SHALL be combinational from state, target tg=pattern[i] and current q_*; all excitations are 0 outside RUN.
REQ-025 SR excitation SHALL be s = tg & ~q_sr and r = ~tg & q_sr; s=r=1 SHALL never occur.
REQ-026 JK excitation SHALL be j = tg and k = ~tg.
REQ-027 T excitation SHALL be t = tg ^ q_t.
REQ-028 Compares SHALL run in every RUN and CHECK cycle: expected = 0 at step 0, pattern[i-1] at step i>0, and pattern[L-1] in CHECK.
REQ-029 A mismatch on any q_* SHALL set the matching err_* flag.
REQ-030 mism_cnt SHALL increment once per compare cycle with at least one mismatch and saturate at 15.
REQ-031 abort=1 in INIT, RUN or CHECK SHALL force IDLE at the next edge with no done pulse; err_* and mism_cnt hold their values.
REQ-032 abort SHALL take priority over a normal state transition; abort in IDLE SHALL be ignored.
REQ-033 start while busy=1 SHALL be ignored, and the latched pattern and len are unchanged.
REQ-034 start and abort high together in IDLE SHALL start a run.

Reset
REQ-035 reset=1 SHALL force IDLE at the next edge, overriding start and abort.
REQ-036 On reset, busy, done, ff_reset, err_* and mism_cnt SHALL be 0, step index 0, and latched pattern and len 0.
REQ-037 With all excitations 0 in IDLE, the external flip-flops SHALL hold their state.
REQ-038 reset mid-run SHALL abandon the run with no done pulse.

Verification
REQ-039 Ideal flip-flop models, pattern=8'b10110010, len=0 (L=8): done in cycle 11; err_*=0 and mism_cnt=0; q_* follow 0,1,0,0,1,1,0,1 with a one-step lag.
REQ-040 Step 0 with q=0 and tg=0 -> s=0, r=0, j=0, k=1, t=0; step 1 with q=0 and tg=1 -> s=1, r=0, j=1, k=0, t=1.
REQ-041 q_t stuck at 0, pattern=8'hFF, len=4 -> err_t=1, err_sr=0, err_jk=0, mism_cnt=4, done in cycle 7.
REQ-042 abort asserted in cycle 4 of an L=8 run -> busy=0 in cycle 5; no done; excitations 0 from cycle 5.
REQ-043 start re-asserted during RUN with a different pattern -> ignored; the run completes on the original pattern.
REQ-044 reset in cycle 3 of a run, then start with len=3 -> outputs 0 after reset; the new run gives done in cycle 6 relative to its own start.
